// File: rtl/mul_issue.sv
// Issue stage between the integer pipeline and an external 64x64 multiplier.
// Latches one request, issues it, selects the result half and holds it for writeback.
module mul_issue (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_flush,
    output logic        m_mulw,
    output logic [1:0]  m_signed,
    output logic [63:0] m_multiplicand,
    output logic [63:0] m_multiplier,
    input  logic        m_out_valid,
    input  logic [63:0] m_hi,
    input  logic [63:0] m_lo
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              m_flush_q, m_flush_d;
    logic              m_mulw_q, m_mulw_d;
    logic [1:0]        m_signed_q, m_signed_d;
    logic [XLEN-1:0]   m_mcand_q, m_mcand_d;
    logic [XLEN-1:0]   m_mplier_q, m_mplier_d;
    logic [XLEN-1:0]   result_c;

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    // Writeback value chosen from the multiplier halves by the latched op
    always_comb begin
        result_c = m_hi;
        if (word_q) begin
            result_c = sext_word(m_lo[WLEN-1:0]);
        end else if (op_q == OP_MUL) begin
            result_c = m_lo;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        word_d     = word_q;
        out_data_d = out_data_q;
        m_flush_d  = 1'b0;
        m_mulw_d   = m_mulw_q;
        m_signed_d = m_signed_q;
        m_mcand_d  = m_mcand_q;
        m_mplier_d = m_mplier_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    op_d     = op;
                    word_d   = word;
                    m_mulw_d = word;
                    if (word) begin
                        m_signed_d = 2'b11;
                        m_mcand_d  = sext_word(src1[WLEN-1:0]);
                        m_mplier_d = sext_word(src2[WLEN-1:0]);
                    end else begin
                        m_signed_d = (op == OP_MULHU)  ? 2'b00 :
                                     (op == OP_MULHSU) ? 2'b10 : 2'b11;
                        m_mcand_d  = src1;
                        m_mplier_d = src2;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (m_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result landing with the flush already finished the op; nothing to cancel
                if (flush) begin
                    if (m_out_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        m_flush_d = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end else if (m_out_valid) begin
                    out_data_d = result_c;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (m_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            word_q     <= 1'b0;
            out_data_q <= '0;
            m_flush_q  <= 1'b0;
            m_mulw_q   <= 1'b0;
            m_signed_q <= 2'b00;
            m_mcand_q  <= '0;
            m_mplier_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            word_q     <= word_d;
            out_data_q <= out_data_d;
            m_flush_q  <= m_flush_d;
            m_mulw_q   <= m_mulw_d;
            m_signed_q <= m_signed_d;
            m_mcand_q  <= m_mcand_d;
            m_mplier_q <= m_mplier_d;
        end
    end

    // Flush must suppress the issue handshake in the same cycle it arrives
    assign m_valid        = (state_q == S_ISSUE) && !flush;
    assign in_ready       = (state_q == S_IDLE);
    assign out_valid      = (state_q == S_DONE);
    assign out_data       = out_data_q;
    assign m_flush        = m_flush_q;
    assign m_mulw         = m_mulw_q;
    assign m_signed       = m_signed_q;
    assign m_multiplicand = m_mcand_q;
    assign m_multiplier   = m_mplier_q;

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue: directed corner ops, randomized ops against
// an arithmetic reference, flush in every state, reset mid-operation.
module tb_mul_issue;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_flush;
    logic        m_mulw;
    logic [1:0]  m_signed;
    logic [63:0] m_multiplicand;
    logic [63:0] m_multiplier;
    logic        m_out_valid;
    logic [63:0] m_hi;
    logic [63:0] m_lo;

    int checks;
    int failures;

    mul_issue dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .word           (word),
        .src1           (src1),
        .src2           (src2),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_flush        (m_flush),
        .m_mulw         (m_mulw),
        .m_signed       (m_signed),
        .m_multiplicand (m_multiplicand),
        .m_multiplier   (m_multiplier),
        .m_out_valid    (m_out_valid),
        .m_hi           (m_hi),
        .m_lo           (m_lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] ext(input logic [63:0] v, input logic s);
        return s ? {{64{v[63]}}, v} : {64'd0, v};
    endfunction

    // Architectural result of the requested operation, straight from the op definitions
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  aw;
        logic [63:0]  bw;
        if (w) begin
            aw = {{32{a[31]}}, a[31:0]};
            bw = {{32{b[31]}}, b[31:0]};
            p  = ext(aw, 1'b1) * ext(bw, 1'b1);
            return {{32{p[31]}}, p[31:0]};
        end
        case (o)
            2'b00:   begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[63:0];   end
            2'b01:   begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[127:64]; end
            2'b10:   begin p = ext(a, 1'b1) * ext(b, 1'b0); return p[127:64]; end
            default: begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[127:64]; end
        endcase
    endfunction

    // External multiplier: full 128-bit product with per-operand signedness
    function automatic logic [127:0] mul_model(input logic [63:0] x, input logic [63:0] y,
                                               input logic [1:0] s);
        return ext(x, s[1]) * ext(y, s[0]);
    endfunction

    task automatic pulse_result();
        logic [127:0] p;
        p = mul_model(m_multiplicand, m_multiplier, m_signed);
        m_hi = p[127:64];
        m_lo = p[63:0];
        m_out_valid = 1'b1;
        tick();
        m_out_valid = 1'b0;
        m_hi = {$urandom, $urandom};
        m_lo = {$urandom, $urandom};
    endtask

    task automatic accept_and_issue(input logic [1:0] o, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1; op = o; word = w; src1 = a; src2 = b;
        tick();
        in_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int rdly, input int lat, input int bp);
        logic [63:0] exp_r, exp_a, exp_b;
        logic [1:0]  exp_s;
        exp_r = ref_result(o, w, a, b);
        exp_a = w ? {{32{a[31]}}, a[31:0]} : a;
        exp_b = w ? {{32{b[31]}}, b[31:0]} : b;
        exp_s = w ? 2'b11 : (o == 2'b11) ? 2'b00 : (o == 2'b10) ? 2'b10 : 2'b11;

        in_valid = 1'b1; op = o; word = w; src1 = a; src2 = b;
        tick();
        in_valid = 1'b0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        checks++;
        if (m_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL issue_valid: m_valid=%b in_ready=%b want 1/0", m_valid, in_ready);
        end
        checks++;
        if (m_signed !== exp_s || m_mulw !== w) begin
            failures++;
            $display("FAIL issue_ctrl: m_signed=%b m_mulw=%b want %b/%b", m_signed, m_mulw, exp_s, w);
        end
        checks++;
        if (m_multiplicand !== exp_a || m_multiplier !== exp_b) begin
            failures++;
            $display("FAIL issue_operands: got %h %h want %h %h",
                     m_multiplicand, m_multiplier, exp_a, exp_b);
        end
        repeat (rdly) begin
            tick();
            checks++;
            if (m_valid !== 1'b1) begin
                failures++;
                $display("FAIL issue_hold: m_valid=%b want 1", m_valid);
            end
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_state: m_valid=%b out_valid=%b want 0/0", m_valid, out_valid);
        end
        repeat (lat - 1) tick();
        pulse_result();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_r || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL result: out_valid=%b out_data=%h in_ready=%b want 1/%h/0",
                     out_valid, out_data, in_ready, exp_r);
        end
        repeat (bp) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_r || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure: out_valid=%b out_data=%h in_ready=%b want 1/%h/0",
                         out_valid, out_data, in_ready, exp_r);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL writeback: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; op = 2'b01; word = 1'b1;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'd0 || m_valid !== 1'b0 ||
            m_flush !== 1'b0 || m_mulw !== 1'b0 || m_signed !== 2'b00 ||
            m_multiplicand !== 64'd0 || m_multiplier !== 64'd0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%h m_valid=%b m_flush=%b m_mulw=%b m_signed=%b mc=%h mp=%h",
                     in_ready, out_valid, out_data, m_valid, m_flush, m_mulw, m_signed,
                     m_multiplicand, m_multiplier);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_op(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0);
        run_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 0);
        run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 3, 1);
        run_op(2'b01, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 2, 1, 0);
        run_op(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        run_op(2'b01, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 2, 5);
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(0, 3) == 0) b = {32'h0, 32'h8000_0000};
            run_op(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), a, b,
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                   int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 0);
        end
    endtask

    task automatic test_flush_idle();
        in_valid = 1'b1; flush = 1'b1; src1 = 64'd5; src2 = 64'd7;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: in_ready=%b m_valid=%b want 1/0", in_ready, m_valid);
        end
    endtask

    task automatic test_flush_issue();
        in_valid = 1'b1; op = 2'b00; word = 1'b0; src1 = 64'd9; src2 = 64'd9;
        tick();
        in_valid = 1'b0;
        m_ready = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_issue_mvalid: m_valid=%b want 0", m_valid);
        end
        tick();
        m_ready = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || m_flush !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_issue_idle: in_ready=%b m_flush=%b m_valid=%b want 1/0/0",
                     in_ready, m_flush, m_valid);
        end
    endtask

    task automatic test_flush_wait();
        int flush_cnt;
        int ov_seen;
        flush_cnt = 0; ov_seen = 0;
        accept_and_issue(2'b00, 1'b0, 64'd11, 64'd13);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (m_flush === 1'b1) flush_cnt++;
        checks++;
        if (m_flush !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait_drain: m_flush=%b in_ready=%b out_valid=%b want 1/0/0",
                     m_flush, in_ready, out_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (m_flush === 1'b1) flush_cnt++;
        if (out_valid === 1'b1) ov_seen++;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_flush_hold: in_ready=%b want 0", in_ready);
        end
        repeat (2) begin
            tick();
            if (m_flush === 1'b1) flush_cnt++;
            if (out_valid === 1'b1) ov_seen++;
        end
        pulse_result();
        if (out_valid === 1'b1) ov_seen++;
        checks++;
        if (in_ready !== 1'b1 || flush_cnt != 1 || ov_seen != 0) begin
            failures++;
            $display("FAIL flush_wait_discard: in_ready=%b m_flush_cycles=%0d out_valid_cycles=%0d want 1/1/0",
                     in_ready, flush_cnt, ov_seen);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || m_flush !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait_after: out_valid=%b m_flush=%b want 0/0", out_valid, m_flush);
        end
    endtask

    task automatic test_flush_done();
        accept_and_issue(2'b00, 1'b0, 64'd6, 64'd7);
        pulse_result();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'd42) begin
            failures++;
            $display("FAIL flush_done_setup: out_valid=%b out_data=%h want 1/%h",
                     out_valid, out_data, 64'd42);
        end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        accept_and_issue(2'b11, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || m_valid !== 1'b0 || out_data !== 64'd0 || m_signed !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid: in_ready=%b m_valid=%b out_data=%h m_signed=%b want 1/0/0/00",
                     in_ready, m_valid, out_data, m_signed);
        end
        pulse_result();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL late_result_ignored: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        run_op(2'b00, 1'b0, 64'd100, 64'd200, 0, 1, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; in_valid = 1'b0; op = 2'b00; word = 1'b0;
        src1 = 64'd0; src2 = 64'd0; flush = 1'b0; out_ready = 1'b0;
        m_ready = 1'b0; m_out_valid = 1'b0; m_hi = 64'd0; m_lo = 64'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush_idle();
        test_flush_issue();
        test_flush_wait();
        test_flush_done();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
